mcu_ncu_ds_rcv: RTL
===================

Name: mcu_ncu_ds_rcv

Overview:
- MCU-side receiver for the NCU-to-MCU downstream nibble bus (ncu_mcuN_vld / ncu_mcuN_data / mcuN_ncu_stall).
- Deserialises 4-bit nibbles into 128-bit request packets: 64-bit header, then 64-bit data.
- Buffers packets in a small FIFO and presents them to the MCU request logic with a valid/ready handshake.
- Drives mcu_ncu_stall for backpressure; one instance per MCU.

Parameters:
- NIB_W, 4, width of the serial data bus in bits.
- PKT_NIBS, 32, nibbles per packet (PKT_NIBS*NIB_W = packet width, 128).
- BUF_DEPTH, 2, completed-packet FIFO entries (power of 2, ≥2).

Ports:
- iol2clk  in  1  sole clock; all state on the rising edge.
- rst_l  in  1  asynchronous active-low reset.
- ncu_mcu_vld  in  1  high on every nibble cycle of a packet.
- ncu_mcu_data  in  NIB_W  nibble; nibble 0 = bits [3:0], least-significant first.
- mcu_ncu_stall  out  1  registered backpressure to the NCU.
- pkt_vld  out  1  FIFO head holds a valid packet.
- pkt_data  out  PKT_NIBS*NIB_W  FIFO head packet; [63:0] header, [127:64] data.
- pkt_rdy  in  1  consumer accepts the head when pkt_vld & pkt_rdy.
- frm_err  out  1  one-cycle pulse when a truncated packet is discarded.
- ovf_err  out  1  sticky; set when a packet arrives while full; cleared only by reset.

Behaviour:
- Reset (async, rst_l=0) clears all outputs to 0 (mcu_ncu_stall, pkt_vld, frm_err, ovf_err), FIFO pointers and count to 0, FSM to IDLE, nibble counter to 0; pkt_data contents don't-care while pkt_vld=0.
- Reset asserted mid-packet discards the partial packet and all buffered packets with no error flagged. After release the block waits in IDLE for a fresh vld.
- Framing: a packet is PKT_NIBS consecutive cycles with ncu_mcu_vld=1. The first vld cycle after IDLE is nibble 0. Back-to-back packets are allowed with no idle gap.
- FSM states:
  - IDLE: on vld, if free slots > 0 store nibble 0, set cnt=1, go to RCV. If vld arrives and FIFO is full (count==BUF_DEPTH), set ovf_err, set cnt=1, go to DROP.
  - RCV: on vld, shift nibble into assembly register at position cnt and increment cnt. When cnt==PKT_NIBS-1, write the assembled packet to the FIFO in that same cycle, clear cnt, return to IDLE. If vld=0 while in RCV, discard the partial packet, pulse frm_err for 1 cycle, go to IDLE.
  - DROP: consume nibbles without storing, using the same cnt logic; return to IDLE after PKT_NIBS nibbles. If vld drops early, return to IDLE and pulse frm_err.
- Latency: last nibble sampled at edge N; pkt_vld=1 and pkt_data valid after edge N (visible cycle N+1).
- FIFO:
  - Write on packet completion; pop on pkt_vld & pkt_rdy. Simultaneous write and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo BUF_DEPTH.
  - pkt_data is stable while pkt_vld=1 and pkt_rdy=0.
- Stall:
  - mcu_ncu_stall is registered. Its next value is 1 iff (count_next + (FSM_next==RCV ? 1 : 0)) ≥ BUF_DEPTH, so the slot being filled counts as occupied.
  - The NCU may not begin a new packet in a cycle where it samples stall=1. Stall never aborts a packet already in flight.
  - A packet that starts anyway while full goes to DROP and sets ovf_err.
- frm_err and ovf_err are independent. A truncation in DROP pulses frm_err only; ovf_err was already set on entry.

Test Plan:
- Single packet: 32 vld cycles carrying nibble i = i[3:0], pkt_rdy=1 → pkt_vld for 1 cycle, one cycle after the last nibble; pkt_data = 128'hFEDCBA9876543210FEDCBA9876543210; stall stays 0.
- Backpressure: pkt_rdy=0, send 2 packets back-to-back → stall=1 from the cycle after packet 2's first nibble is sampled; both packets are retained. Then pkt_rdy=1 → packets pop in order; stall drops to 0 the cycle after the first pop.
- Overflow: FIFO full, drive a third packet ignoring stall → ovf_err=1 and stays 1; FIFO contents unchanged; the next packet after a pop is received correctly.
- Truncation: vld for 10 nibbles, then low → frm_err pulses 1 cycle; no pkt_vld; a following full packet of all 4'hA → pkt_data = 128'hAAAA…AA.
- Simultaneous: the last nibble of packet 2 arrives in the same cycle packet 1 is popped → count stays 1; stall=0; packet 2 appears at the head the next cycle.
- Reset mid-packet: rst_l=0 at nibble 15 → all outputs 0 immediately (asynchronous). After release, a full packet is received with no errors.

Source files
------------

// File: rtl/mcu_ncu_ds_rcv_if.sv
// NCU-to-MCU downstream nibble bus plus the MCU-side packet handshake.
// master: NCU/consumer side, slave: the receiver.
interface mcu_ncu_ds_rcv_if #(
  parameter int unsigned NIB_W    = 4,
  parameter int unsigned PKT_NIBS = 32
);
  logic                      ncu_mcu_vld;
  logic [NIB_W-1:0]          ncu_mcu_data;
  logic                      mcu_ncu_stall;
  logic                      pkt_vld;
  logic [NIB_W*PKT_NIBS-1:0] pkt_data;
  logic                      pkt_rdy;
  logic                      frm_err;
  logic                      ovf_err;

  modport master (
    output ncu_mcu_vld, ncu_mcu_data, pkt_rdy,
    input  mcu_ncu_stall, pkt_vld, pkt_data, frm_err, ovf_err
  );

  modport slave (
    input  ncu_mcu_vld, ncu_mcu_data, pkt_rdy,
    output mcu_ncu_stall, pkt_vld, pkt_data, frm_err, ovf_err
  );
endinterface

// File: rtl/mcu_ncu_ds_rcv.sv
// MCU-side receiver for the NCU downstream nibble bus: assembles nibbles
// (LSB nibble first) into packets, buffers them in a small FIFO and
// presents them over a valid/ready handshake with registered backpressure.
module mcu_ncu_ds_rcv #(
  parameter int unsigned NIB_W     = 4,
  parameter int unsigned PKT_NIBS  = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic               iol2clk,
  input logic               rst_l,
  mcu_ncu_ds_rcv_if.slave   bus
);

  localparam int unsigned PKT_W  = NIB_W * PKT_NIBS;
  localparam int unsigned NCNT_W = $clog2(PKT_NIBS);
  localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);

  localparam logic [NCNT_W-1:0] LAST_NIB = NCNT_W'(PKT_NIBS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RCV  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NCNT_W-1:0]  nib_q, nib_d;
  logic [PKT_W-1:0]   asm_q, asm_d, asm_ins;
  logic               wr_en;
  logic               pop;
  logic               full;
  logic               frm_d, frm_q;
  logic               ovf_set, ovf_q;
  logic               stall_d, stall_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W:0]     occ;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PKT_W-1:0]   mem [BUF_DEPTH];

  assign full = (count_q == FULL_CNT);
  assign pop  = (count_q != '0) && bus.pkt_rdy;

  // Assembly register with the current nibble dropped into slot nib_q.
  always_comb begin
    asm_ins = asm_q;
    for (int unsigned i = 0; i < PKT_NIBS; i++) begin
      if (nib_q == NCNT_W'(i)) asm_ins[i*NIB_W +: NIB_W] = bus.ncu_mcu_data;
    end
  end

  // Framing FSM: next state, nibble counter, packet write and error strobes.
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    asm_d   = asm_q;
    wr_en   = 1'b0;
    frm_d   = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ncu_mcu_vld) begin
          nib_d = NCNT_W'(1);
          if (!full) begin
            asm_d   = asm_ins;
            state_d = RCV;
          end else begin
            ovf_set = 1'b1;
            state_d = DROP;
          end
        end
      end
      RCV: begin
        if (bus.ncu_mcu_vld) begin
          asm_d = asm_ins;
          if (nib_q == LAST_NIB) begin
            wr_en   = 1'b1;
            nib_d   = '0;
            state_d = IDLE;
          end else begin
            nib_d = nib_q + NCNT_W'(1);
          end
        end else begin
          frm_d   = 1'b1;
          nib_d   = '0;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (bus.ncu_mcu_vld) begin
          if (nib_q == LAST_NIB) begin
            nib_d   = '0;
            state_d = IDLE;
          end else begin
            nib_d = nib_q + NCNT_W'(1);
          end
        end else begin
          frm_d   = 1'b1;
          nib_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        nib_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO occupancy and stall: a slot being filled counts as occupied.
  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    occ     = {1'b0, count_d} + {{CNT_W{1'b0}}, (state_d == RCV)};
    stall_d = (occ >= {1'b0, FULL_CNT});
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      nib_q    <= '0;
      asm_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      stall_q  <= 1'b0;
      frm_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      asm_q   <= asm_d;
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      stall_q <= stall_d;
      frm_q   <= frm_d;
      ovf_q   <= ovf_q | ovf_set;
    end
  end

  // Packet storage; contents are don't-care until written.
  always_ff @(posedge iol2clk) begin
    if (wr_en) mem[wr_ptr_q] <= asm_d;
  end

  assign bus.mcu_ncu_stall = stall_q;
  assign bus.pkt_vld       = (count_q != '0);
  assign bus.pkt_data      = mem[rd_ptr_q];
  assign bus.frm_err       = frm_q;
  assign bus.ovf_err       = ovf_q;

endmodule
